// File: rtl/psram_ddr_tx_gearbox_if.sv
// Write-data stream into the PSRAM DDR transmit gearbox.
//   s_data  : write word, WORD_W bits
//   s_valid : s_data valid (driven by the master)
//   s_ready : gearbox accepts s_data this cycle (driven by the slave)
interface psram_ddr_tx_gearbox_if #(
   parameter int WORD_W = 32
) ();
   logic [WORD_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/psram_ddr_tx_gearbox.sv
// PSRAM DQ transmit gearbox, feeding the ODDR bank.
// Takes a burst of WORD_W-bit words from a valid/ready stream and presents
// one D0/D1 byte pair per clock, MSB slice first, plus the ODDR TX enable.
// Ports:
//   sys_clk, sys_rst    : clock (also ODDR CLK), synchronous active-high reset
//   start, burst_len    : burst request (sampled in IDLE), length in words
//   busy                : burst in progress
//   s_if (slave)        : write-word stream
//   d0, d1              : ODDR D0 (rising half) / D1 (falling half)
//   tx_oen              : ODDR TX, 1 = DQ high-Z, 0 = drive
//   done, underrun      : one-cycle completion / starvation-abort pulses
//
// state | meaning
// IDLE  | bus released, waiting for start with non-zero burst_len
// PRIME | s_ready high, waiting (indefinitely) for the first word
// SEND  | driving one beat per clock; reloads on the last beat of each word
module psram_ddr_tx_gearbox #(
   parameter int DQ_W   = 8,
   parameter int WORD_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  start,
   input  logic [LEN_W-1:0]      burst_len,
   output logic                  busy,
   psram_ddr_tx_gearbox_if.slave s_if,
   output logic [DQ_W-1:0]       d0,
   output logic [DQ_W-1:0]       d1,
   output logic                  tx_oen,
   output logic                  done,
   output logic                  underrun
);

   // WORD_W must be a whole multiple of 2*DQ_W.
   localparam int BEATS  = WORD_W / (2 * DQ_W);
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_SEND  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  words_left_q, words_left_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [DQ_W-1:0]   d0_q, d0_d, d1_q, d1_d;
   logic              busy_q, busy_d;
   logic              s_ready_q, s_ready_d;
   logic              tx_oen_q, tx_oen_d;
   logic              done_q, done_d;
   logic              underrun_q, underrun_d;
   logic              accept;
   logic              last_beat;

   assign accept    = s_if.s_valid & s_ready_q;
   assign last_beat = (beat_q == LAST_BEAT);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= ST_IDLE;
         words_left_q <= '0;
         beat_q       <= '0;
         shreg_q      <= '0;
         d0_q         <= '0;
         d1_q         <= '0;
         busy_q       <= 1'b0;
         s_ready_q    <= 1'b0;
         tx_oen_q     <= 1'b1;
         done_q       <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         words_left_q <= words_left_d;
         beat_q       <= beat_d;
         shreg_q      <= shreg_d;
         d0_q         <= d0_d;
         d1_q         <= d1_d;
         busy_q       <= busy_d;
         s_ready_q    <= s_ready_d;
         tx_oen_q     <= tx_oen_d;
         done_q       <= done_d;
         underrun_q   <= underrun_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      words_left_d = words_left_q;
      beat_d       = beat_q;
      shreg_d      = shreg_q;
      d0_d         = '0;
      d1_d         = '0;
      busy_d       = busy_q;
      s_ready_d    = 1'b0;
      tx_oen_d     = 1'b1;
      done_d       = 1'b0;
      underrun_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (start && (burst_len != '0)) begin
               words_left_d = burst_len;
               busy_d       = 1'b1;
               s_ready_d    = 1'b1;
               state_d      = ST_PRIME;
            end
         end

         ST_PRIME: begin
            s_ready_d = 1'b1;
            if (accept) begin
               d0_d         = s_if.s_data[WORD_W-1 -: DQ_W];
               d1_d         = s_if.s_data[WORD_W-1-DQ_W -: DQ_W];
               shreg_d      = s_if.s_data << (2 * DQ_W);
               beat_d       = '0;
               words_left_d = words_left_q - 1'b1;
               tx_oen_d     = 1'b0;
               state_d      = ST_SEND;
            end
         end

         ST_SEND: begin
            if (!last_beat) begin
               d0_d     = shreg_q[WORD_W-1 -: DQ_W];
               d1_d     = shreg_q[WORD_W-1-DQ_W -: DQ_W];
               shreg_d  = shreg_q << (2 * DQ_W);
               beat_d   = beat_q + 1'b1;
               tx_oen_d = 1'b0;
            end else if (words_left_q == '0) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (accept) begin
               // Reload on the last beat so the next word follows with no bubble.
               d0_d         = s_if.s_data[WORD_W-1 -: DQ_W];
               d1_d         = s_if.s_data[WORD_W-1-DQ_W -: DQ_W];
               shreg_d      = s_if.s_data << (2 * DQ_W);
               beat_d       = '0;
               words_left_d = words_left_q - 1'b1;
               tx_oen_d     = 1'b0;
            end else begin
               // The PSRAM cannot be stalled mid-burst: abort and release DQ.
               underrun_d = 1'b1;
               busy_d     = 1'b0;
               state_d    = ST_IDLE;
            end
         end

         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      // While driving, ready is only offered on the beat that can take the next word.
      if (!tx_oen_d) begin
         s_ready_d = (beat_d == LAST_BEAT) && (words_left_d != '0);
      end
   end

   assign busy         = busy_q;
   assign s_if.s_ready = s_ready_q;
   assign d0           = d0_q;
   assign d1           = d1_q;
   assign tx_oen       = tx_oen_q;
   assign done         = done_q;
   assign underrun     = underrun_q;

endmodule
